melody_seq: RTL and testbench
=============================

Name: melody_seq

Overview:
- Programmable note sequencer that drives note selection into the tone-select/buzzer stage.
- Steps through a small writable score RAM of (note, duration) entries, one duration unit per tick strobe from the shared strobe generator.
- Outputs the current note index (0..6 = C,D,E,F,G,A,Bb; 7 = rest) and a gate.
- Supports play, stop, loop and end-of-score detection.

Parameters:
- LEN, 16, number of score entries; power of two, 2..256.
- AW, 4, score address width; must equal log2(LEN).
- GAP, 1, silent ticks inserted after each note (articulation); 0 = legato, max 15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  tick strobe, one-cycle pulse; one duration unit per pulse.
- play  in  1  one-cycle start request.
- stop  in  1  one-cycle abort request.
- loop  in  1  level; 1 = restart at entry 0 after end of score.
- wr_en  in  1  score write enable.
- wr_addr  in  AW  score write address.
- wr_data  in  7  score entry {note[6:4], dur[3:0]}.
- note_sel  out  3  current note index; 7 = rest.
- gate  out  1  1 while a non-rest note sounds.
- busy  out  1  1 in any state except IDLE.
- done  out  1  one-cycle pulse on natural end of score.
- pos  out  AW  index of entry being played.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; note_sel=7, gate=0, busy=0, done=0, pos=0; all score entries cleared to 0.
- Entry with dur=0 is the end marker.
- Score RAM:
  - Writes take effect at the clk edge and are allowed in any state.
  - A read of the same address in the same cycle returns the old data.
- FSM states: IDLE, FETCH, NOTE, PAUSE.
- IDLE:
  - play=1 and stop=0 -> pos<=0, go to FETCH.
  - en is ignored.
- FETCH (exactly one cycle), reads entry[pos]:
  - dur=0 -> end-of-score handling.
  - Otherwise: note_sel<=note, gate<=(note!=7), cnt<=dur, go to NOTE.
- NOTE, on each en:
  - cnt>1 -> cnt<=cnt-1.
  - cnt=1 -> gate<=0, note_sel<=7.
    - GAP>0: gcnt<=GAP, go to PAUSE.
    - GAP=0: advance.
  - Gate is therefore high for exactly dur en pulses, counting from the first en after FETCH.
- PAUSE, on each en:
  - gcnt>1 -> gcnt<=gcnt-1.
  - gcnt=1 -> advance.
- Advance:
  - pos<LEN-1 -> pos<=pos+1, go to FETCH.
  - pos=LEN-1 -> end-of-score handling.
- End-of-score handling:
  - loop=1 and pos!=0 -> pos<=0, go to FETCH.
  - Otherwise -> IDLE, done=1 for one cycle, note_sel=7, gate=0.
  - The pos!=0 condition stops an empty score from looping forever.
- Stop:
  - stop=1 in any state -> IDLE next cycle; gate=0, note_sel=7, pos unchanged, no done.
  - stop has priority over play, en and end-of-score handling in the same cycle.
- play while busy=1 is ignored; there is no restart.
- loop is sampled only at end-of-score handling, so changing it mid-score affects the next end only.
- Latency: play at edge t -> FETCH in cycle t+1 -> gate/note_sel valid from edge t+2.
- busy=1 from the cycle after an accepted play until IDLE is re-entered.
- en arriving during FETCH is dropped; the strobe period is assumed much longer than one cycle.
- Counters: cnt is 4 bits, gcnt is 4 bits; pos wraps only through end-of-score handling, never by overflow.
- Reset asserted mid-playback: all outputs return to reset values at the next edge; the score is cleared.

Test Plan:
- Reset -> score all 0, note_sel=7, gate=0, busy=0; then play -> FETCH sees dur=0 -> done pulse 2 cycles after play, busy low again, no loop even with loop=1.
- Write entries 0:{C,dur2}, 1:{E,dur3}, 2:{0,0}; GAP=1; play with en every 10 cycles:
  - gate high for 2 en, note_sel=0, then 1 en silent;
  - gate high for 3 en, note_sel=2, then 1 en silent;
  - done pulse; pos sequence 0,1,2.
- Same score with loop=1 -> after entry 1 the sequencer returns to pos=0 with no done pulse and note_sel=0 again; clear loop mid-score -> done after the next end marker.
- Rest entry {7,dur4} -> gate=0 and note_sel=7 for 4 en while busy=1; LEN=16 with no end marker and loop=0 -> done after entry 15.
- stop during NOTE on entry 1 -> next cycle IDLE, gate=0, pos=1, no done; stop and play in the same cycle from IDLE -> stays IDLE.
- Write entry 1 while entry 0 plays -> new data played; wr_addr equal to pos during FETCH -> old data played; rst_n low mid-note -> all outputs at reset values next edge.

Source files
------------

// File: rtl/melody_seq.sv
// Note sequencer: plays (note, duration) entries from a writable score RAM,
// one duration unit per tick strobe, with optional articulation gap and looping.
module melody_seq #(
    parameter int LEN = 16,
    parameter int AW  = 4,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          play,
    input  logic          stop,
    input  logic          loop,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    output logic [2:0]    note_sel,
    output logic          gate,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pos
);
    localparam logic [2:0]    REST  = 3'd7;
    localparam logic [AW-1:0] LAST  = AW'(LEN - 1);
    localparam logic [3:0]    GAP_W = 4'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_PAUSE} state_t;

    state_t        r_state, w_state_nxt;
    logic [6:0]    r_score [LEN];
    logic [AW-1:0] r_pos, w_pos_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [3:0]    r_gcnt, w_gcnt_nxt;
    logic [2:0]    r_note, w_note_nxt;
    logic          r_gate, w_gate_nxt;
    logic          r_done, w_done_nxt;
    logic [6:0]    w_entry;
    logic          w_adv;
    logic          w_end;

    // Asynchronous read: a same-cycle write lands at the edge, so FETCH sees old data.
    assign w_entry = r_score[r_pos];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_note_nxt  = r_note;
        w_gate_nxt  = r_gate;
        w_done_nxt  = 1'b0;
        w_adv       = 1'b0;
        w_end       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (play) begin
                    w_pos_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_entry[3:0] == 4'd0) begin
                    w_end = 1'b1;
                end else begin
                    w_note_nxt  = w_entry[6:4];
                    w_gate_nxt  = (w_entry[6:4] != REST);
                    w_cnt_nxt   = w_entry[3:0];
                    w_state_nxt = S_NOTE;
                end
            end
            S_NOTE: begin
                if (en) begin
                    if (r_cnt > 4'd1) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_note_nxt = REST;
                        w_gate_nxt = 1'b0;
                        if (GAP > 0) begin
                            w_gcnt_nxt  = GAP_W;
                            w_state_nxt = S_PAUSE;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (en) begin
                    if (r_gcnt > 4'd1) begin
                        w_gcnt_nxt = r_gcnt - 4'd1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_adv) begin
            if (r_pos != LAST) begin
                w_pos_nxt   = r_pos + AW'(1);
                w_state_nxt = S_FETCH;
            end else begin
                w_end = 1'b1;
            end
        end

        // Looping requires pos != 0 so an empty score cannot spin forever.
        if (w_end) begin
            if (loop && (r_pos != '0)) begin
                w_pos_nxt   = '0;
                w_state_nxt = S_FETCH;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_note_nxt  = REST;
                w_gate_nxt  = 1'b0;
            end
        end

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_pos_nxt   = r_pos;
            w_note_nxt  = REST;
            w_gate_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos  <= '0;
            r_cnt  <= '0;
            r_gcnt <= '0;
            r_note <= REST;
            r_gate <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                r_score[i] <= '0;
            end
        end else begin
            r_pos  <= w_pos_nxt;
            r_cnt  <= w_cnt_nxt;
            r_gcnt <= w_gcnt_nxt;
            r_note <= w_note_nxt;
            r_gate <= w_gate_nxt;
            r_done <= w_done_nxt;
            if (wr_en) begin
                r_score[wr_addr] <= wr_data;
            end
        end
    end

    assign note_sel = r_note;
    assign gate     = r_gate;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign pos      = r_pos;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: the expected output per tick slot is derived by flattening
// the score into a list of (busy, note, gate, pos) observations.
module tb_melody_seq;
    localparam int LEN = 16;
    localparam int AW  = 4;
    localparam int GAP = 1;

    typedef logic [8:0] obs_t;  // {busy, note_sel, gate, pos}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          play = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [6:0]    wr_data = '0;
    logic [2:0]    note_sel;
    logic          gate;
    logic          busy;
    logic          done;
    logic [AW-1:0] pos;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [6:0] m_score [LEN];
    obs_t       slots[$];
    int         end_pos;
    int         wrap_slot;

    melody_seq #(.LEN(LEN), .AW(AW), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .play(play), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note_sel(note_sel), .gate(gate), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic obs_t obs();
        return {busy, note_sel, gate, pos};
    endfunction

    // Each entry yields dur sounding slots then GAP silent slots; end marker or
    // the last entry ends the score, optionally wrapping up to 'wraps' times.
    function automatic void build(input int wraps);
        int p = 0;
        int w = 0;
        bit fin = 1'b0;
        logic [2:0] nt;
        logic [3:0] dur;
        slots.delete();
        wrap_slot = -1;
        end_pos = 0;
        while (!fin) begin
            nt  = m_score[p][6:4];
            dur = m_score[p][3:0];
            if (dur != 4'd0) begin
                for (int i = 0; i < int'(dur); i++) slots.push_back({1'b1, nt, nt != 3'd7, 4'(p)});
                for (int i = 0; i < GAP; i++) slots.push_back({1'b1, 3'd7, 1'b0, 4'(p)});
            end
            if (dur != 4'd0 && p < LEN - 1) begin
                p++;
            end else if (w < wraps && p != 0) begin
                w++;
                p = 0;
                wrap_slot = slots.size();
            end else begin
                end_pos = p;
                fin = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic wr(input int a, input logic [6:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_score();
        for (int i = 0; i < LEN; i++) wr(i, m_score[i]);
    endtask

    task automatic pulse_play();
        @(negedge clk); play = 1'b1;
        @(negedge clk); play = 1'b0;
    endtask

    task automatic en_step();
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // wmode 1: write mid-slot wslot; wmode 2: write in the FETCH cycle entering wslot.
    task automatic run(input string tag, input int wraps, input int stop_slot,
                       input int wmode, input int wslot, input int waddr, input logic [6:0] wdata);
        int base;
        int k;
        build(wraps);
        base = done_cnt;
        loop = (wraps > 0);
        pulse_play();
        repeat (2) @(negedge clk);
        k = 0;
        while (k < slots.size()) begin
            chk($sformatf("%s_slot%0d", tag, k), 32'(obs()), 32'(slots[k]));
            if (k == wrap_slot) loop = 1'b0;
            if (wmode == 1 && k == wslot) wr(waddr, wdata);
            if (k == stop_slot) begin
                @(negedge clk); stop = 1'b1;
                @(negedge clk); stop = 1'b0;
                chk($sformatf("%s_stop", tag), 32'(obs()), 32'({1'b0, 3'd7, 1'b0, slots[k][3:0]}));
                repeat (2) @(negedge clk);
                chk($sformatf("%s_stop_nodone", tag), 32'(done_cnt - base), 32'd0);
                loop = 1'b0;
                return;
            end
            @(negedge clk); en = 1'b1;
            @(negedge clk); en = 1'b0;
            if (wmode == 2 && k + 1 == wslot) begin
                wr_en = 1'b1; wr_addr = AW'(waddr); wr_data = wdata;
                @(negedge clk);
                wr_en = 1'b0;
            end
            repeat (3) @(negedge clk);
            k++;
        end
        chk($sformatf("%s_idle", tag), 32'(obs()), 32'({1'b0, 3'd7, 1'b0, 4'(end_pos)}));
        chk($sformatf("%s_done", tag), 32'(done_cnt - base), 32'd1);
        loop = 1'b0;
    endtask

    task automatic basic_score();
        for (int i = 0; i < LEN; i++) m_score[i] = 7'h00;
        m_score[0] = 7'h02;  // C, 2 ticks
        m_score[1] = 7'h23;  // E, 3 ticks
    endtask

    initial begin
        int base;
        for (int i = 0; i < LEN; i++) m_score[i] = 7'h00;

        repeat (3) @(negedge clk);
        chk("reset_obs", 32'(obs()), 32'({1'b0, 3'd7, 1'b0, 4'd0}));
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Empty score: done two cycles after play, no looping even with loop=1.
        loop = 1'b1;
        base = done_cnt;
        pulse_play();
        chk("empty_fetch", 32'(obs()), 32'({1'b1, 3'd7, 1'b0, 4'd0}));
        @(negedge clk);
        chk("empty_end", 32'({done, obs()}), 32'({1'b1, 1'b0, 3'd7, 1'b0, 4'd0}));
        @(negedge clk);
        chk("empty_done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_done_once", 32'(done_cnt - base), 32'd1);
        chk("empty_stays_idle", 32'(busy), 32'd0);
        loop = 1'b0;

        basic_score();
        load_score();
        run("basic", 0, -1, 0, 0, 0, 7'h00);
        run("loop", 1, -1, 0, 0, 0, 7'h00);

        // Rest entry first, full score without end marker.
        m_score[0] = 7'h74;
        for (int i = 1; i < LEN; i++) m_score[i] = {3'($urandom_range(0, 7)), 4'($urandom_range(1, 2))};
        load_score();
        run("full", 0, -1, 0, 0, 0, 7'h00);

        basic_score();
        load_score();
        run("stop", 0, 3, 0, 0, 0, 7'h00);
        @(negedge clk); stop = 1'b1; play = 1'b1;
        @(negedge clk); stop = 1'b0; play = 1'b0;
        @(negedge clk);
        chk("stop_play_idle", 32'(obs()), 32'({1'b0, 3'd7, 1'b0, 4'd1}));

        m_score[1] = 7'h45;
        run("wr_live", 0, -1, 1, 0, 1, 7'h45);
        run("wr_fetch", 0, -1, 2, 3, 1, 7'h31);
        m_score[1] = 7'h31;
        run("wr_after", 0, -1, 0, 0, 0, 7'h00);

        // Reset in the middle of entry 1.
        basic_score();
        load_score();
        pulse_play();
        repeat (2) @(negedge clk);
        en_step(); en_step(); en_step();
        chk("mid_note", 32'(obs()), 32'({1'b1, 3'd2, 1'b1, 4'd1}));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_obs", 32'(obs()), 32'({1'b0, 3'd7, 1'b0, 4'd0}));
        chk("mid_reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < LEN; i++) m_score[i] = 7'h00;
        run("cleared", 0, -1, 0, 0, 0, 7'h00);

        for (int it = 0; it < 6; it++) begin
            int wraps;
            int sslot;
            for (int i = 0; i < LEN; i++) begin
                logic [3:0] d;
                d = ($urandom_range(0, 9) == 0 && it != 5) ? 4'd0 : 4'($urandom_range(1, 4));
                m_score[i] = {3'($urandom_range(0, 7)), d};
            end
            wraps = int'($urandom_range(0, 1));
            sslot = (it == 2) ? int'($urandom_range(0, 12)) : -1;
            load_score();
            run($sformatf("rand%0d", it), wraps, sslot, 0, 0, 0, 7'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
